// File: rtl/stone_pkg.sv
// Stone RAM word layout, type/colour codes and renderer FSM types shared by
// stone_renderer and the optional sprite ROM (STONE_SPRITE_EN).
package stone_pkg;

  localparam int X_MSB    = 31;
  localparam int X_LSB    = 23;
  localparam int Y_MSB    = 18;
  localparam int Y_LSB    = 11;
  localparam int TYPE_MSB = 3;
  localparam int TYPE_LSB = 2;
  localparam int VIS_BIT  = 1;
  localparam int MOV_BIT  = 0;

  localparam logic [1:0] T_STONE   = 2'b00;
  localparam logic [1:0] T_GOLD    = 2'b01;
  localparam logic [1:0] T_DIAMOND = 2'b10;

  localparam logic [2:0] C_STONE   = 3'b111;
  localparam logic [2:0] C_GOLD    = 3'b110;
  localparam logic [2:0] C_DIAMOND = 3'b011;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_PLOT, S_NEXT, S_DONE
  } state_e;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [1:0] kind;
  } stone_t;

  function automatic stone_t unpack_stone(input logic [31:0] d);
    stone_t s;
    s.x    = d[X_MSB:X_LSB];
    s.y    = d[Y_MSB:Y_LSB];
    s.kind = d[TYPE_MSB:TYPE_LSB];
    return s;
  endfunction

  // Both diamond codes (10 and 11) share one colour.
  function automatic logic [2:0] colour_of(input logic [1:0] kind);
    case (kind)
      T_STONE: return C_STONE;
      T_GOLD:  return C_GOLD;
      default: return C_DIAMOND;
    endcase
  endfunction

endpackage

// File: rtl/stone_sprite_rom.sv
// Synchronous 4 x 256 x 3 sprite ROM, present only with STONE_SPRITE_EN.
// Colour 3'b000 marks a transparent pixel; the four corners are transparent.
`ifdef STONE_SPRITE_EN
module stone_sprite_rom
  import stone_pkg::*;
(
  input  logic       clock,
  input  logic [9:0] addr,
  output logic [2:0] colour
);

  function automatic logic [2:0] sprite_px(input logic [9:0] a);
    logic [3:0] r, c;
    r = a[7:4];
    c = a[3:0];
    if ((r == 4'd0 || r == 4'd15) && (c == 4'd0 || c == 4'd15)) return 3'b000;
    return colour_of(a[9:8]);
  endfunction

  always_ff @(posedge clock) colour <= sprite_px(addr);

endmodule
`endif

// File: rtl/stone_renderer.sv
// Per-frame stone renderer: scans the stone RAM and expands each visible stone
// into a SIZE x SIZE block of clipped VGA pixel writes. Sprite mode: STONE_SPRITE_EN.
module stone_renderer
  import stone_pkg::*;
#(
  parameter int SIZE     = 16,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int READ_LAT = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] data,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done
);

  localparam int            CW        = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST      = CW'(SIZE - 1);
  localparam logic [7:0]    WAIT_INIT = 8'(READ_LAT - 1);

  state_e        state;
  stone_t        stn;
  logic [CW-1:0] col, row;
  logic [7:0]    wait_cnt;
  logic [9:0]    px, py;
  logic          in_range, last_px;

  // 10-bit sums so stones near the right/bottom edge clip instead of wrapping.
  assign px       = 10'(stn.x) + 10'(col);
  assign py       = 10'(stn.y) + 10'(row);
  assign in_range = (px < 10'(SCREEN_W)) && (py < 10'(SCREEN_H));
  assign last_px  = (col == LAST) && (row == LAST);

  logic unused_bits;
  assign unused_bits = ^{data[X_LSB-1:Y_MSB+1], data[Y_LSB-1:TYPE_MSB+1], data[MOV_BIT]};

`ifdef STONE_SPRITE_EN
  logic [2:0] rom_colour;
  logic       tail, s_vld, s_in;
  logic [8:0] s_x;
  logic [7:0] s_y;

  stone_sprite_rom u_rom (
    .clock  (clock),
    .addr   ({stn.kind, 4'(row), 4'(col)}),
    .colour (rom_colour)
  );
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      draw_stone_flag <= 1'b0;
      draw_index      <= '0;
      x               <= '0;
      y               <= '0;
      colour          <= '0;
      plot            <= 1'b0;
      done            <= 1'b0;
      stn             <= '0;
      col             <= '0;
      row             <= '0;
      wait_cnt        <= '0;
`ifdef STONE_SPRITE_EN
      tail            <= 1'b0;
      s_vld           <= 1'b0;
      s_in            <= 1'b0;
      s_x             <= '0;
      s_y             <= '0;
`endif
    end else begin
      done <= 1'b0;
      plot <= 1'b0;
`ifdef STONE_SPRITE_EN
      // ROM output lines up with the pixel issued one cycle earlier.
      s_vld <= 1'b0;
      if (s_vld && s_in && rom_colour != 3'b000) begin
        plot   <= 1'b1;
        x      <= s_x;
        y      <= s_y;
        colour <= rom_colour;
      end
`endif
      case (state)
        S_IDLE: if (start) begin
          draw_stone_flag <= 1'b1;
          draw_index      <= '0;
          state           <= S_ADDR;
        end
        S_ADDR: if (draw_index >= quantity) state <= S_DONE;
        else begin
          wait_cnt <= WAIT_INIT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt <= 8'd1) state <= S_LATCH;
        end
        S_LATCH: begin
          stn <= unpack_stone(data);
          if (data[VIS_BIT]) begin
            col   <= '0;
            row   <= '0;
            state <= S_PLOT;
          end else state <= S_NEXT;
        end
        S_PLOT: begin
`ifdef STONE_SPRITE_EN
          if (tail) begin
            tail  <= 1'b0;
            state <= S_NEXT;
          end else begin
            s_vld <= 1'b1;
            s_in  <= in_range;
            s_x   <= px[8:0];
            s_y   <= py[7:0];
            if (last_px) tail <= 1'b1;
`else
          begin
            if (in_range) begin
              plot   <= 1'b1;
              x      <= px[8:0];
              y      <= py[7:0];
              colour <= colour_of(stn.kind);
            end
            if (last_px) state <= S_NEXT;
`endif
            if (col == LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else col <= col + 1'b1;
          end
        end
        S_NEXT: begin
          draw_index <= draw_index + 4'd1;
          state      <= S_ADDR;
        end
        S_DONE: begin
          draw_stone_flag <= 1'b0;
          done            <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stone_renderer.sv
// Directed bench for stone_renderer (default build): a two-stage RAM model
// feeds data; a negedge monitor gathers per-pass statistics that are checked.
module tb_stone_renderer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  quantity = '0;
  logic [31:0] data;
  logic        draw_stone_flag, plot, done;
  logic [3:0]  draw_index;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;

  int n_chk = 0, n_err = 0;

  stone_renderer dut (
    .clock(clock), .resetn(resetn), .start(start), .quantity(quantity), .data(data),
    .draw_stone_flag(draw_stone_flag), .draw_index(draw_index), .x(x), .y(y),
    .colour(colour), .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  // RAM model: data reflects mem[draw_index] two cycles after the index moves.
  logic [31:0] mem [16];
  logic [31:0] d1;
  always @(posedge clock) begin
    d1   <= mem[draw_index];
    data <= d1;
  end

  function automatic logic [31:0] mk(input int sx, input int sy, input logic [1:0] t,
                                     input logic vis, input logic mov);
    logic [8:0] xx;
    logic [7:0] yy;
    xx = 9'(sx);
    yy = 8'(sy);
    return {xx, 4'b0, yy, 7'b0, t, vis, mov};
  endfunction

  // Monitor statistics, cleared at the start of each pass.
  int n_flag, n_plot, n_done, plots_idx1, bad_col, idx_max;
  int first_x, first_y, last_x, last_y, min_x, max_x, min_y, max_y;
  logic [2:0]  first_col, last_col, exp_col;
  logic [15:0] idx_mask;

  always @(negedge clock) begin
    if (draw_stone_flag) begin
      n_flag++;
      idx_mask[draw_index] = 1'b1;
      if (int'(draw_index) > idx_max) idx_max = int'(draw_index);
    end
    if (done) n_done++;
    if (plot) begin
      if (n_plot == 0) begin
        first_x = int'(x); first_y = int'(y); first_col = colour;
      end
      last_x = int'(x); last_y = int'(y); last_col = colour;
      if (int'(x) < min_x) min_x = int'(x);
      if (int'(x) > max_x) max_x = int'(x);
      if (int'(y) < min_y) min_y = int'(y);
      if (int'(y) > max_y) max_y = int'(y);
      if (draw_index == 4'd1) plots_idx1++;
      if (colour != exp_col) bad_col++;
      n_plot++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_flag = 0; n_plot = 0; n_done = 0; plots_idx1 = 0; bad_col = 0; idx_max = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    min_x = 9999; max_x = -1; min_y = 9999; max_y = -1;
    first_col = '0; last_col = '0; idx_mask = '0;
  endtask

  // Pulses start and waits for done; cyc counts negedges until done is seen.
  task automatic run_pass(input logic [3:0] q, input int repulse, output int cyc);
    @(posedge clock);
    clear_stats();
    quantity = q;
    @(negedge clock);
    start = 1'b1;
    cyc = 0;
    while (cyc < 4000) begin
      @(negedge clock);
      cyc++;
      start = (cyc == repulse);
      if (done) break;
    end
    start = 1'b0;
    if (cyc >= 4000) check("pass_timeout", cyc, -1);
    @(negedge clock);
    #1;
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    exp_col = 3'b000;
    clear_stats();

    // Reset state
    #12;
    check("rst_flag",  int'(draw_stone_flag), 0);
    check("rst_index", int'(draw_index), 0);
    check("rst_plot",  int'(plot), 0);
    check("rst_done",  int'(done), 0);
    check("rst_x",     int'(x), 0);
    check("rst_y",     int'(y), 0);
    check("rst_col",   int'(colour), 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // quantity=0: flag for ADDR and DONE only
    run_pass(4'd0, -1, cyc);
    check("q0_cyc",   cyc, 3);
    check("q0_flag",  n_flag, 2);
    check("q0_plots", n_plot, 0);
    check("q0_done",  n_done, 1);

    // single gold stone; the moving bit must not matter
    mem[0] = mk(100, 50, 2'b01, 1'b1, 1'b1);
    exp_col = 3'b110;
    run_pass(4'd1, -1, cyc);
    check("q1_cyc",     cyc, 263);
    check("q1_flag",    n_flag, 262);
    check("q1_plots",   n_plot, 256);
    check("q1_first_x", first_x, 100);
    check("q1_first_y", first_y, 50);
    check("q1_last_x",  last_x, 115);
    check("q1_last_y",  last_y, 65);
    check("q1_badcol",  bad_col, 0);
    check("q1_done",    n_done, 1);
    check("q1_hold_x",  int'(x), 115);

    // three entries, middle one invisible
    mem[0] = mk(10, 20, 2'b00, 1'b1, 1'b0);
    mem[1] = mk(50, 50, 2'b01, 1'b0, 1'b0);
    mem[2] = mk(200, 100, 2'b10, 1'b1, 1'b0);
    exp_col = 3'bxxx;
    run_pass(4'd3, -1, cyc);
    check("q3_flag",      n_flag, 526);
    check("q3_plots",     n_plot, 512);
    check("q3_idx1_plot", plots_idx1, 0);
    check("q3_idx_mask",  int'(idx_mask), 16'h000F);
    check("q3_idx_max",   idx_max, 3);
    check("q3_first_col", int'(first_col), 3'b111);
    check("q3_last_col",  int'(last_col), 3'b011);
    check("q3_first_xy",  first_x * 1000 + first_y, 10020);
    check("q3_last_xy",   last_x * 1000 + last_y, 215115);

    // clipping at the bottom-right corner
    mem[0] = mk(310, 230, 2'b11, 1'b1, 1'b0);
    exp_col = 3'b011;
    run_pass(4'd1, -1, cyc);
    check("clip_flag",  n_flag, 262);
    check("clip_plots", n_plot, 100);
    check("clip_min_x", min_x, 310);
    check("clip_max_x", max_x, 319);
    check("clip_min_y", min_y, 230);
    check("clip_max_y", max_y, 239);
    check("clip_badcol", bad_col, 0);

    // quantity=15, all invisible: index 15 is addressed but never read
    for (int i = 0; i < 16; i++) mem[i] = '0;
    run_pass(4'd15, -1, cyc);
    check("q15_flag",    n_flag, 62);
    check("q15_plots",   n_plot, 0);
    check("q15_idx_max", idx_max, 15);

    // start re-pulsed mid-pass is ignored
    mem[0] = mk(100, 50, 2'b01, 1'b1, 1'b0);
    exp_col = 3'b110;
    run_pass(4'd1, 100, cyc);
    check("rep_flag",  n_flag, 262);
    check("rep_plots", n_plot, 256);
    check("rep_done",  n_done, 1);

    // reset during S_PLOT abandons the pass
    @(posedge clock);
    clear_stats();
    quantity = 4'd1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (n_plot < 20 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    check("abort_reach_plot", int'(n_plot >= 20), 1);
    #2 resetn = 1'b0;
    #1;
    check("abort_flag", int'(draw_stone_flag), 0);
    check("abort_plot", int'(plot), 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("abort_no_done", n_done, 0);

    // fresh pass after reset starts from index 0
    run_pass(4'd1, -1, cyc);
    check("post_flag",    n_flag, 262);
    check("post_plots",   n_plot, 256);
    check("post_first_x", first_x, 100);
    check("post_first_y", first_y, 50);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stone_renderer.md
Name: stone_renderer

Overview:
- Downstream consumer of the stone RAM that the rope controller updates.
- Once per frame it walks stone entries 0..quantity-1 through the shared read port (draw_stone_flag/draw_index).
- Each visible stone is expanded into a SIZE×SIZE block of pixel writes for the VGA adapter.
- While it owns the RAM port, the rope controller stalls its frame-tick states.

Parameters:
- SIZE, 16, sprite edge in pixels (matches the rope hit box).
- SCREEN_W, 320, horizontal clip limit.
- SCREEN_H, 240, vertical clip limit.
- READ_LAT, 2, cycles from draw_index change to valid data.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a render pass
- quantity  in  4  number of stone entries to scan
- data  in  32  stone word from the RAM read port
- draw_stone_flag  out  1  high for the whole pass; steers the RAM read address
- draw_index  out  4  entry currently addressed
- x  out  9  pixel X
- y  out  8  pixel Y
- colour  out  3  pixel RGB
- plot  out  1  pixel write strobe
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Clock and reset: one clock domain. Async active-low reset. Ports clock and resetn.
- Stone word fields:
  - X = data[31:23]
  - Y = data[18:11]
  - type = data[3:2]
  - visible = data[1]
  - moving = data[0]
- Reset values: all outputs 0; state S_IDLE.
- S_IDLE:
  - start=1 → draw_stone_flag=1, draw_index=0, go to S_ADDR.
  - start is ignored in every other state.
- S_ADDR:
  - If draw_index >= quantity → S_DONE.
  - Otherwise load wait counter = READ_LAT-1 → S_WAIT.
- S_WAIT: decrement counter; at 0 → S_LATCH.
- S_LATCH: latch X, Y, type and visible from data.
  - visible=1 → clear col/row → S_PLOT.
  - visible=0 → S_NEXT.
  - The moving bit does not affect drawing; a stone on the hook is drawn at its stored position.
- S_PLOT: one pixel per cycle, row-major.
  - x = X+col and y = Y+row, computed 10 bits wide.
  - plot=1 only when X+col < SCREEN_W and Y+row < SCREEN_H; clipped pixels still take a cycle, with plot=0.
  - After col=SIZE-1, row=SIZE-1 → S_NEXT.
  - Cost: exactly SIZE² cycles per visible stone.
- S_NEXT: draw_index+1 → S_ADDR.
- S_DONE: draw_stone_flag=0, done=1 for one cycle → S_IDLE.
- Colour map:
  - type 00 → 3'b111 (stone)
  - type 01 → 3'b110 (gold)
  - types 10 and 11 → 3'b011 (diamond)
- quantity=0: flag high for exactly 2 cycles (S_ADDR, S_DONE), no plot.
- draw_index never exceeds quantity. Index 15 with quantity=15 is not read.
- draw_stone_flag is registered. It is held constant, with draw_index stable, throughout S_WAIT/S_LATCH so the RAM mux never glitches.
- Reset mid-pass: flag, plot and done drop asynchronously; the pass is abandoned, with no resume.
- x/y/colour are valid only when plot=1; otherwise they hold their last values.
- Pass length: 2 + Σ(READ_LAT+2) over scanned entries + SIZE²·(visible count) cycles.

Optional Feature:
- Macro STONE_SPRITE_EN.
- When defined:
  - colour comes from stone_sprite_rom indexed by {type, row[3:0], col[3:0]}.
  - Pixels where the ROM returns 3'b000 are transparent (plot=0).
  - The ROM is synchronous with 1-cycle latency; x/y/plot are delayed one cycle to align, and S_PLOT gains one trailing cycle per stone.
- When undefined: solid colour per the colour map; no ROM is instantiated.

Decomposition:
- Package stone_pkg:
  - Field bit positions: X_MSB/LSB, Y_MSB/LSB, TYPE_MSB/LSB, VIS_BIT, MOV_BIT.
  - Type codes: T_STONE, T_GOLD, T_DIAMOND.
  - Colour constants.
  - SCREEN_W/H defaults.
- Sub-module stone_sprite_rom:
  - 4 types × 256 entries × 3 bits.
  - Present only under STONE_SPRITE_EN.

Test Plan:
- quantity=0, start pulse → draw_stone_flag high 2 cycles, done on cycle 3, zero plot strobes.
- quantity=1, data={X=100,Y=50,type=01,vis=1} → 256 plots; first (100,50), last (115,65), colour 3'b110, done after 2+4+256 cycles.
- quantity=3, entries 0 and 2 visible, entry 1 has vis=0 → 512 plots; draw_index sequence 0,1,2; no plots while index=1.
- Stone at X=310,Y=230 → only x∈[310,319], y∈[230,239] plotted (100 strobes); pass still 256 plot-state cycles.
- start re-pulsed mid-pass, then resetn low during S_PLOT → the second start is ignored; on reset, flag and plot clear immediately with no done pulse; a new start after reset runs from index 0.
- STONE_SPRITE_EN with ROM zeros at the corners → corner pixels not plotted; plot lags the S_PLOT entry by 1 cycle.
